// File: rtl/ad9911_cfg_ctrl_pkg.sv
// Shared definitions for the AD9911 configuration controller: FSM encodings,
// register addresses, frame lengths and the frame alignment helper.
package ad9911_cfg_ctrl_pkg;

  // Main controller states; the 3-bit encoding is fully used, but any
  // corrupted value still falls back to IDLE through the case default.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MRST   = 3'd1,
    ST_LOCK   = 3'd2,
    ST_CSR_WR = 3'd3,
    ST_GAP    = 3'd4,
    ST_FR1_WR = 3'd5,
    ST_FTW_WR = 3'd6,
    ST_IOUP   = 3'd7
  } state_e;

  // Serial shifter phases.
  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_TAIL  = 2'd2
  } sh_state_e;

  // AD9911 register addresses (write, instruction byte = address).
  localparam logic [7:0] ADDR_CSR   = 8'h00;
  localparam logic [7:0] ADDR_FR1   = 8'h01;
  localparam logic [7:0] ADDR_CFTW0 = 8'h04;

  // IO_UPDATE pulse width in cycles and the longest serial frame.
  localparam int unsigned IOUP_CYC  = 2;
  localparam int unsigned FRAME_MAX = 40;

  // Frame lengths in bits (instruction byte included).
  localparam logic [5:0] LEN_CSR = 6'd16;
  localparam logic [5:0] LEN_FR1 = 6'd32;
  localparam logic [5:0] LEN_FTW = 6'd40;

  // Move an nbits-long right-justified frame so its MSB sits at bit 39,
  // which is where the shifter takes the first serial bit from.
  function automatic logic [FRAME_MAX-1:0] left_align(
    input logic [FRAME_MAX-1:0] raw,
    input logic [5:0]           nbits
  );
    return raw << (6'(FRAME_MAX) - nbits);
  endfunction

endpackage

// File: rtl/ad9911_spi_shift.sv
// 3-wire SPI frame shifter for the AD9911. Loads a left-aligned frame on
// start, presents one bit per 2*HALF_PER cycles (SCLK rising mid-bit), holds
// CS_N low for a trailing HALF_PER after the last falling edge and strobes
// done in the final low cycle.
module ad9911_spi_shift
  import ad9911_cfg_ctrl_pkg::*;
#(
  parameter int unsigned HALF_PER = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [5:0]           len_i,
  input  logic [FRAME_MAX-1:0] frame_i,
  output logic                 done_o,
  output logic                 cs_n_o,
  output logic                 sclk_o,
  output logic                 sdio_o
);

  localparam logic [3:0] DIV_LOAD = 4'(HALF_PER - 1);

  sh_state_e             sh_q, sh_d;
  logic [FRAME_MAX-1:0]  shift_q, shift_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]            div_q, div_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  sdio_q, sdio_d;

  // Shifter phase, divider, bit counter and serial line next-state logic.
  always_comb begin
    sh_d      = sh_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sdio_d    = sdio_q;
    case (sh_q)
      SH_IDLE: begin
        if (start_i) begin
          sdio_d    = frame_i[FRAME_MAX-1];
          shift_d   = frame_i << 1;
          bit_cnt_d = len_i - 6'd1;
          div_d     = DIV_LOAD;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          sh_d      = SH_SHIFT;
        end else begin
          cs_n_d = 1'b1;
          sclk_d = 1'b0;
          sdio_d = 1'b0;
        end
      end
      SH_SHIFT: begin
        if (div_q != 4'd0) begin
          div_d = div_q - 4'd1;
        end else begin
          div_d = DIV_LOAD;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: present the next bit, or enter the CS hold tail.
            sclk_d = 1'b0;
            if (bit_cnt_q != 6'd0) begin
              sdio_d    = shift_q[FRAME_MAX-1];
              shift_d   = shift_q << 1;
              bit_cnt_d = bit_cnt_q - 6'd1;
            end else begin
              sh_d = SH_TAIL;
            end
          end
        end
      end
      SH_TAIL: begin
        if (div_q != 4'd0) begin
          div_d = div_q - 4'd1;
        end else begin
          sh_d   = SH_IDLE;
          cs_n_d = 1'b1;
          sdio_d = 1'b0;
        end
      end
      default: begin
        sh_d   = SH_IDLE;
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        sdio_d = 1'b0;
      end
    endcase
  end

  // Shifter state registers; reset aborts any frame with CS_N high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q      <= SH_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= 6'd0;
      div_q     <= 4'd0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      sdio_q    <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      sdio_q    <= sdio_d;
    end
  end

  assign done_o = (sh_q == SH_TAIL) && (div_q == 4'd0);
  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign sdio_o = sdio_q;

endmodule

// File: rtl/ad9911_cfg_ctrl.sv
// AD9911 configuration controller: runs the power-up sequence (MRESET, PLL
// lock wait, CSR and FR1 writes, IO_UPDATE) on INITI, then serves frequency
// updates as CFTW0 writes followed by an IO_UPDATE pulse.
module ad9911_cfg_ctrl
  import ad9911_cfg_ctrl_pkg::*;
#(
  parameter int unsigned HALF_PER = 2,
  parameter int unsigned RST_CYC  = 10,
  parameter int unsigned LOCK_CYC = 10000,
  parameter logic [7:0]  CSR_WORD = 8'h10,
  parameter logic [23:0] FR1_WORD = 24'hD00000
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        INITI,
  output logic        INITIED,
  input  logic [31:0] FREQW,
  input  logic        UPDATE,
  output logic        UPDATED,
  output logic        BUSY,
  output logic        MRESET,
  output logic        CS_N,
  output logic        SCLK,
  output logic        SDIO,
  output logic        IO_UPDATE
);

  localparam int unsigned CNT_MAX = RST_CYC + LOCK_CYC + 2 * HALF_PER + IOUP_CYC;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 initied_q, initied_d;
  logic                 updated_q, updated_d;
  logic                 busy_q, busy_d;
  logic                 mreset_q, mreset_d;
  logic                 io_update_q, io_update_d;

  logic                 start_s;
  logic [5:0]           len_s;
  logic [FRAME_MAX-1:0] frame_s;
  logic                 done_s;

  // Sequencing: next state, phase counter, shifter launch and output levels.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    initied_d = initied_q;
    start_s   = 1'b0;
    len_s     = LEN_FTW;
    frame_s   = '0;
    case (state_q)
      ST_IDLE: begin
        if (!initied_q) begin
          // A pending UPDATE waits here until init has completed.
          if (INITI) begin
            state_d = ST_MRST;
            cnt_d   = CNT_W'(RST_CYC - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (UPDATE) begin
          state_d = ST_FTW_WR;
          start_s = 1'b1;
          len_s   = LEN_FTW;
          frame_s = {ADDR_CFTW0, FREQW};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MRST: begin
        if (cnt_q == '0) begin
          state_d = ST_LOCK;
          cnt_d   = CNT_W'(LOCK_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (cnt_q == '0) begin
          state_d = ST_CSR_WR;
          start_s = 1'b1;
          len_s   = LEN_CSR;
          frame_s = left_align(40'({ADDR_CSR, CSR_WORD}), LEN_CSR);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CSR_WR: begin
        if (done_s) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(2 * HALF_PER - 1);
        end else begin
          state_d = ST_CSR_WR;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_FR1_WR;
          start_s = 1'b1;
          len_s   = LEN_FR1;
          frame_s = left_align(40'({ADDR_FR1, FR1_WORD}), LEN_FR1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FR1_WR, ST_FTW_WR: begin
        if (done_s) begin
          state_d = ST_IOUP;
          cnt_d   = CNT_W'(IOUP_CYC - 1);
        end else begin
          state_d = state_q;
        end
      end
      ST_IOUP: begin
        if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          initied_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the state being entered so they line up with it.
    busy_d      = (state_d != ST_IDLE);
    mreset_d    = (state_d == ST_MRST);
    io_update_d = (state_d == ST_IOUP);
    // Only an update (not the init IO_UPDATE) pulls UPDATED low.
    updated_d   = !((state_d == ST_FTW_WR) || ((state_d == ST_IOUP) && initied_q));
  end

  // Controller registers with asynchronous reset to the idle, uninitialised state.
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      initied_q   <= 1'b0;
      updated_q   <= 1'b1;
      busy_q      <= 1'b0;
      mreset_q    <= 1'b0;
      io_update_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      initied_q   <= initied_d;
      updated_q   <= updated_d;
      busy_q      <= busy_d;
      mreset_q    <= mreset_d;
      io_update_q <= io_update_d;
    end
  end

  ad9911_spi_shift #(
    .HALF_PER (HALF_PER)
  ) u_spi (
    .clk     (CLOCK_10M),
    .rst_n   (RESET_N),
    .start_i (start_s),
    .len_i   (len_s),
    .frame_i (frame_s),
    .done_o  (done_s),
    .cs_n_o  (CS_N),
    .sclk_o  (SCLK),
    .sdio_o  (SDIO)
  );

  assign INITIED   = initied_q;
  assign UPDATED   = updated_q;
  assign BUSY      = busy_q;
  assign MRESET    = mreset_q;
  assign IO_UPDATE = io_update_q;

endmodule

// File: tb/tb_ad9911_cfg_ctrl.sv
// Self-checking bench for ad9911_cfg_ctrl. An expected waveform and frame
// list are built from the sequencing rules (phase lengths, frame bit timing)
// and compared with a cycle-by-cycle capture of the DUT outputs. Instance A
// uses HALF_PER=2, instance B HALF_PER=1; both use LOCK_CYC=100.
module tb_ad9911_cfg_ctrl;

  localparam int MAXC = 600;
  localparam int RST  = 10;
  localparam int LOCK = 100;
  localparam int S_CS = 0, S_SCLK = 1, S_MR = 2, S_IU = 3, S_UPD = 4, S_BUSY = 5, S_INI = 6;

  typedef struct {
    int          n;
    logic [39:0] v;
  } frm_t;

  logic clk = 1'b0;
  logic rst_n;
  logic a_initi, a_upd, b_initi, b_upd;
  logic [31:0] a_fw, b_fw;
  logic a_initied, a_updated, a_busy, a_mreset, a_cs_n, a_sclk, a_sdio, a_ioup;
  logic b_initied, b_updated, b_busy, b_mreset, b_cs_n, b_sclk, b_sdio, b_ioup;

  int n_pass  = 0;
  int n_total = 0;
  int ncyc_g  = 0;

  bit          e_w [7][MAXC];
  logic        o_w [7][MAXC];
  logic        o_sdio [MAXC];
  bit          d_init [MAXC];
  bit          d_raise [MAXC];
  logic [31:0] d_fw [MAXC];
  frm_t        exp_q[$];
  frm_t        got_q[$];
  string       sname [7] = '{"cs_n", "sclk", "mreset", "io_update", "updated", "busy", "initied"};

  always #5 clk = ~clk;

  ad9911_cfg_ctrl #(.HALF_PER(2), .RST_CYC(RST), .LOCK_CYC(LOCK)) dut_a (
    .CLOCK_10M(clk), .RESET_N(rst_n), .INITI(a_initi), .INITIED(a_initied),
    .FREQW(a_fw), .UPDATE(a_upd), .UPDATED(a_updated), .BUSY(a_busy),
    .MRESET(a_mreset), .CS_N(a_cs_n), .SCLK(a_sclk), .SDIO(a_sdio), .IO_UPDATE(a_ioup)
  );

  ad9911_cfg_ctrl #(.HALF_PER(1), .RST_CYC(RST), .LOCK_CYC(LOCK)) dut_b (
    .CLOCK_10M(clk), .RESET_N(rst_n), .INITI(b_initi), .INITIED(b_initied),
    .FREQW(b_fw), .UPDATE(b_upd), .UPDATED(b_updated), .BUSY(b_busy),
    .MRESET(b_mreset), .CS_N(b_cs_n), .SCLK(b_sclk), .SDIO(b_sdio), .IO_UPDATE(b_ioup)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic set_rng(input int k, input int a, input int b, input bit val);
    for (int c = a; c <= b; c++) if (c >= 0 && c < MAXC) e_w[k][c] = val;
  endtask

  task automatic m_clear(input bit ini);
    for (int c = 0; c < MAXC; c++) begin
      e_w[S_CS][c] = 1'b1;  e_w[S_SCLK][c] = 1'b0; e_w[S_MR][c] = 1'b0;
      e_w[S_IU][c] = 1'b0;  e_w[S_UPD][c]  = 1'b1; e_w[S_BUSY][c] = 1'b0;
      e_w[S_INI][c] = ini;
    end
  endtask

  // Frame starting (CS_N low, first bit) at cycle s; returns length in cycles.
  task automatic m_frame(input int s, input int n, input int hp, input logic [39:0] v, output int len);
    frm_t f;
    len = hp + 2 * hp * n;
    set_rng(S_CS, s, s + len - 1, 1'b0);
    for (int k = 0; k < n; k++) set_rng(S_SCLK, s + 2*hp*k + hp, s + 2*hp*k + 2*hp - 1, 1'b1);
    if (s + len < ncyc_g) begin
      f.n = n; f.v = v;
      exp_q.push_back(f);
    end
  endtask

  // Init requested (INITI seen) in cycle c0; t_ready = first idle, initialised cycle.
  task automatic m_init(input int c0, input int hp, output int t_ready);
    int s, s2, l1, l2, e;
    set_rng(S_MR, c0 + 1, c0 + RST, 1'b1);
    s = c0 + RST + LOCK + 1;
    m_frame(s, 16, hp, 40'h0010, l1);
    s2 = s + l1 + 2 * hp;
    m_frame(s2, 32, hp, 40'h01D00000, l2);
    e = s2 + l2;
    set_rng(S_IU, e, e + 1, 1'b1);
    set_rng(S_BUSY, c0 + 1, e + 1, 1'b1);
    set_rng(S_INI, e + 2, MAXC - 1, 1'b1);
    t_ready = e + 2;
  endtask

  // Update accepted in cycle t with word fw; nxt = first idle cycle after it.
  task automatic m_update(input int t, input logic [31:0] fw, input int hp, output int nxt);
    int l, e;
    m_frame(t + 1, 40, hp, {8'h04, fw}, l);
    e = t + 1 + l;
    set_rng(S_IU, e, e + 1, 1'b1);
    set_rng(S_UPD, t + 1, e + 1, 1'b0);
    set_rng(S_BUSY, t + 1, e + 1, 1'b1);
    nxt = e + 2;
  endtask

  // ---------------- stimulus / capture ----------------
  task automatic prep(input int n);
    ncyc_g = n;
    exp_q.delete();
    for (int i = 0; i < MAXC; i++) begin
      d_init[i] = 1'b0; d_raise[i] = 1'b0; d_fw[i] = $urandom;
    end
  endtask

  // Starts at #1 after a rising edge; samples, then drives, once per cycle.
  // The requester drops UPDATE once it sees UPDATED low.
  task automatic capture(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      o_w[S_CS][i]   = sel ? b_cs_n    : a_cs_n;
      o_w[S_SCLK][i] = sel ? b_sclk    : a_sclk;
      o_w[S_MR][i]   = sel ? b_mreset  : a_mreset;
      o_w[S_IU][i]   = sel ? b_ioup    : a_ioup;
      o_w[S_UPD][i]  = sel ? b_updated : a_updated;
      o_w[S_BUSY][i] = sel ? b_busy    : a_busy;
      o_w[S_INI][i]  = sel ? b_initied : a_initied;
      o_sdio[i]      = sel ? b_sdio    : a_sdio;
      if (sel) begin
        b_initi = d_init[i]; b_fw = d_fw[i];
        if (d_raise[i]) b_upd = 1'b1;
        else if (b_updated === 1'b0) b_upd = 1'b0;
      end else begin
        a_initi = d_init[i]; a_fw = d_fw[i];
        if (d_raise[i]) a_upd = 1'b1;
        else if (a_updated === 1'b0) a_upd = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic compare(input string sc);
    int m, nb, bad;
    logic [39:0] v;
    frm_t f;
    for (int k = 0; k < 7; k++) begin
      m = -1;
      for (int c = 0; c < ncyc_g; c++) if (m < 0 && o_w[k][c] !== e_w[k][c]) m = c;
      if (m < 0) m = 0;
      check($sformatf("%s_%s@%0d", sc, sname[k], m), 64'(o_w[k][m]), 64'(e_w[k][m]));
    end
    got_q.delete();
    v = '0; nb = 0; bad = 0;
    for (int c = 1; c < ncyc_g; c++) begin
      if (o_w[S_CS][c] === 1'b0) begin
        if (o_w[S_SCLK][c] === 1'b1 && o_w[S_SCLK][c-1] === 1'b0) begin
          v = {v[38:0], o_sdio[c]}; nb++;
        end
      end else begin
        if (o_w[S_CS][c-1] === 1'b0) begin
          f.n = nb; f.v = v; got_q.push_back(f);
          v = '0; nb = 0;
        end
        if (o_sdio[c] !== 1'b0) bad++;
      end
    end
    check($sformatf("%s_nframes", sc), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_frame%0d_nbits", sc, i), 64'(got_q[i].n), 64'(exp_q[i].n));
      check($sformatf("%s_frame%0d_data", sc, i), 64'(got_q[i].v), 64'(exp_q[i].v));
    end
    check($sformatf("%s_sdio_zero_when_cs_high", sc), 64'(bad), 64'd0);
  endtask

  task automatic check_a_idle_reset(input string sc);
    check({sc, "_cs_n"}, 64'(a_cs_n), 64'd1);
    check({sc, "_sclk"}, 64'(a_sclk), 64'd0);
    check({sc, "_sdio"}, 64'(a_sdio), 64'd0);
    check({sc, "_io_update"}, 64'(a_ioup), 64'd0);
    check({sc, "_mreset"}, 64'(a_mreset), 64'd0);
    check({sc, "_initied"}, 64'(a_initied), 64'd0);
    check({sc, "_updated"}, 64'(a_updated), 64'd1);
    check({sc, "_busy"}, 64'(a_busy), 64'd0);
  endtask

  initial begin
    int t, nx, nx2, d;
    rst_n = 1'b0;
    a_initi = 1'b0; a_upd = 1'b0; a_fw = 32'h0;
    b_initi = 1'b0; b_upd = 1'b0; b_fw = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_a_idle_reset("reset");
    rst_n = 1'b1;

    // UPDATE pending before INITI; init then the pending update (random FREQW every cycle)
    prep(500);
    d_raise[0] = 1'b1;
    for (int i = 5; i < MAXC; i++) d_init[i] = 1'b1;
    m_clear(1'b0);
    m_init(5, 2, t);
    m_update(t, d_fw[t], 2, nx);
    capture(1'b0, 500);
    compare("init_pending_upd");

    // Directed update 0x147AE148, INITI toggling (ignored once initialised)
    prep(180);
    d_raise[0] = 1'b1;
    for (int i = 0; i < MAXC; i++) begin
      d_fw[i] = 32'h147AE148; d_init[i] = 1'($urandom_range(0, 1));
    end
    m_clear(1'b1);
    m_update(0, 32'h147AE148, 2, nx);
    capture(1'b0, 180);
    compare("upd_147ae148");

    // Back-to-back updates, second raised on the cycle UPDATED returns high
    prep(340);
    d_raise[0] = 1'b1;
    d_raise[165] = 1'b1;
    for (int i = 0; i < MAXC; i++) d_fw[i] = (i < 165) ? 32'h00000001 : 32'hFFFFFFFF;
    m_clear(1'b1);
    m_update(0, 32'h00000001, 2, nx);
    m_update(nx, 32'hFFFFFFFF, 2, nx2);
    capture(1'b0, 340);
    compare("b2b");

    // Random start delays with FREQW changing every cycle
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(0, 7);
      prep(175 + d);
      d_raise[d] = 1'b1;
      m_clear(1'b1);
      m_update(d, d_fw[d], 2, nx);
      capture(1'b0, 175 + d);
      compare($sformatf("rand%0d", r));
    end

    // Reset while bit 20 of the CFTW0 frame is on the line
    prep(84);
    d_raise[0] = 1'b1;
    m_clear(1'b1);
    m_update(0, d_fw[0], 2, nx);
    capture(1'b0, 84);
    compare("pre_abort");
    rst_n = 1'b0;
    #2;
    check_a_idle_reset("abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // After reset an update must not be served without a new init
    prep(200);
    d_raise[0] = 1'b1;
    m_clear(1'b0);
    capture(1'b0, 200);
    compare("post_abort");
    a_upd = 1'b0;

    // HALF_PER=1 instance: INITI and UPDATE together, init first then update
    prep(320);
    d_raise[0] = 1'b1;
    for (int i = 0; i < MAXC; i++) d_init[i] = 1'b1;
    m_clear(1'b0);
    m_init(0, 1, t);
    m_update(t, d_fw[t], 1, nx);
    capture(1'b1, 320);
    compare("hp1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
